// File: rtl/usb4_deskew_pkg.sv
// Shared types and defaults for the two-lane receive deskew stage.
package usb4_deskew_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEARCH  = 2'd1,
      ALIGNED = 2'd2
   } deskew_state_e;

   localparam logic [7:0] DESKEW_MARKER   = 8'hA5;
   localparam int         DESKEW_MAX_SKEW = 7;

endpackage

// File: rtl/lane_deskew_if.sv
// Decoder-to-deskew lane bytes plus aligned lane pairs and status toward lane bonding.
interface lane_deskew_if;

   logic       enable_deskew;
   logic [7:0] lane_0_rx;
   logic [7:0] lane_1_rx;
   logic [7:0] lane_0_aligned;
   logic [7:0] lane_1_aligned;
   logic       rx_valid;
   logic       deskew_done;
   logic       deskew_error;

   modport master (
      output enable_deskew, lane_0_rx, lane_1_rx,
      input  lane_0_aligned, lane_1_aligned, rx_valid, deskew_done, deskew_error
   );

   modport slave (
      input  enable_deskew, lane_0_rx, lane_1_rx,
      output lane_0_aligned, lane_1_aligned, rx_valid, deskew_done, deskew_error
   );

endinterface

// File: rtl/byte_delay_line.sv
// Per-lane byte history: tap 0 is the live input, tap k the byte received k cycles earlier.
module byte_delay_line #(
   parameter int DEPTH = 8,
   parameter int SEL_W = 3
) (
   input  logic             enc_clk,
   input  logic             rst,
   input  logic [7:0]       din,
   input  logic [SEL_W-1:0] sel,
   output logic [7:0]       tap
);

   logic [DEPTH-1:1][7:0] hist_q, hist_d;

   always_comb begin
      hist_d    = hist_q;
      hist_d[1] = din;
      for (int k = 2; k < DEPTH; k++) hist_d[k] = hist_q[k-1];
   end

   always_ff @(posedge enc_clk or negedge rst) begin
      if (!rst) hist_q <= '0;
      else      hist_q <= hist_d;
   end

   always_comb begin
      tap = din;
      for (int k = 1; k < DEPTH; k++) begin
         if (sel == SEL_W'(k)) tap = hist_q[k];
      end
   end

endmodule

// File: rtl/lane_deskew.sv
// Two-lane marker-based deskew. Optional LANE_DESKEW_MONITOR_EN enables the
// in-lock marker comparator that drops lock when only one lane shows the marker.
module lane_deskew
   import usb4_deskew_pkg::*;
#(
   parameter logic [7:0] MARKER   = DESKEW_MARKER,
   parameter int         MAX_SKEW = DESKEW_MAX_SKEW
) (
   input  logic         enc_clk,
   input  logic         rst,
   lane_deskew_if.slave bus
);

   localparam int NUM_LANES = 2;
   localparam int CW        = $clog2(MAX_SKEW + 1);

   deskew_state_e                 state_q, state_d;
   logic                          early_seen_q, early_seen_d;
   logic                          early_lane_q, early_lane_d;
   logic [CW-1:0]                 skew_cnt_q, skew_cnt_d;
   logic [NUM_LANES-1:0][CW-1:0]  dly_q, dly_d, sel;
   logic [NUM_LANES-1:0][7:0]     lane_rx, tap, aligned_q, aligned_d;
   logic [NUM_LANES-1:0]          mark;
   logic                          lock_q, lock_d;
   logic                          err_q, err_d;

   assign lane_rx = {bus.lane_1_rx, bus.lane_0_rx};
   assign mark    = {lane_rx[1] == MARKER, lane_rx[0] == MARKER};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      byte_delay_line #(.DEPTH(MAX_SKEW + 1), .SEL_W(CW)) u_dly (
         .enc_clk (enc_clk),
         .rst     (rst),
         .din     (lane_rx[i]),
         .sel     (sel[i]),
         .tap     (tap[i])
      );
   end

   // While searching, the select already carries the delays a lock this cycle
   // would latch, so the first aligned output shows both markers.
   always_comb begin
      sel = dly_q;
      if (state_q != ALIGNED) begin
         sel = '0;
         if (early_seen_q) sel[early_lane_q] = skew_cnt_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      early_seen_d = early_seen_q;
      early_lane_d = early_lane_q;
      skew_cnt_d   = skew_cnt_q;
      dly_d        = dly_q;
      err_d        = 1'b0;
      if (!bus.enable_deskew) begin
         state_d      = IDLE;
         early_seen_d = 1'b0;
         early_lane_d = 1'b0;
         skew_cnt_d   = '0;
         dly_d        = '0;
      end else begin
         case (state_q)
            IDLE: state_d = SEARCH;
            SEARCH: begin
               if (!early_seen_q) begin
                  if (&mark) begin
                     state_d = ALIGNED;
                     dly_d   = sel;
                  end else if (|mark) begin
                     early_seen_d = 1'b1;
                     early_lane_d = mark[1];
                     skew_cnt_d   = CW'(1);
                  end
               end else if (mark[~early_lane_q]) begin
                  state_d      = ALIGNED;
                  dly_d        = sel;
                  early_seen_d = 1'b0;
                  skew_cnt_d   = '0;
               end else if (mark[early_lane_q]) begin
                  skew_cnt_d = CW'(1);
               end else if (skew_cnt_q == CW'(MAX_SKEW)) begin
                  err_d        = 1'b1;
                  early_seen_d = 1'b0;
                  skew_cnt_d   = '0;
               end else begin
                  skew_cnt_d = skew_cnt_q + 1'b1;
               end
            end
            ALIGNED: begin
`ifdef LANE_DESKEW_MONITOR_EN
               if ((tap[0] == MARKER) != (tap[1] == MARKER)) begin
                  state_d = SEARCH;
                  dly_d   = '0;
                  err_d   = 1'b1;
               end
`endif
            end
            default: state_d = IDLE;
         endcase
      end
      lock_d    = (state_d == ALIGNED);
      aligned_d = lock_d ? tap : '0;
   end

   always_ff @(posedge enc_clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         early_seen_q <= 1'b0;
         early_lane_q <= 1'b0;
         skew_cnt_q   <= '0;
         dly_q        <= '0;
         aligned_q    <= '0;
         lock_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         early_seen_q <= early_seen_d;
         early_lane_q <= early_lane_d;
         skew_cnt_q   <= skew_cnt_d;
         dly_q        <= dly_d;
         aligned_q    <= aligned_d;
         lock_q       <= lock_d;
         err_q        <= err_d;
      end
   end

   assign bus.lane_0_aligned = aligned_q[0];
   assign bus.lane_1_aligned = aligned_q[1];
   assign bus.rx_valid       = lock_q;
   assign bus.deskew_done    = lock_q;
   assign bus.deskew_error   = err_q;

endmodule
